branch_pc_unit: RTL and testbench

- Consumer end of the branch-compare interface in the single-cycle core.
- Drives the unsigned-compare select into the branch comparator and takes back its equal/less-than flags.
- Resolves branch/JAL/JALR direction and target, and owns the architectural PC register.
- Raises a misaligned-target trap and holds it until the trap is acknowledged.
- Counts taken control transfers.

---
 rtl/branch_pc_unit_pkg.sv | 24 ++
 rtl/branch_pc_unit_cond_dec.sv | 31 +++
 rtl/branch_pc_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_pc_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pc_unit_pkg.sv
// rtl/branch_pc_unit_pkg.sv - shared encodings and defaults for the branch/PC unit
package branch_pc_unit_pkg;

  // Branch funct3 encodings; 010 and 011 are reserved.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_TRAP   = 2'd2,
    ST_VECTOR = 2'd3
  } pcu_state_e;

  // Default PC on reset and after an acknowledged misaligned-target trap.
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/branch_pc_unit_cond_dec.sv
// rtl/branch_pc_unit_cond_dec.sv - branch condition decoder (funct3 + compare flags)
module branch_cond_dec
  import branch_pc_unit_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       cond_o,
  output logic       illegal_o,
  output logic       br_un_o
);

  // funct3[1] distinguishes the unsigned compares; the comparator answers in the same cycle.
  assign br_un_o = funct3_i[1];

  // Evaluate the branch condition; reserved encodings are never taken and flagged illegal.
  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = br_eq_i;
      F3_BNE:  cond_o = ~br_eq_i;
      F3_BLT:  cond_o = br_lt_i;
      F3_BLTU: cond_o = br_lt_i;
      F3_BGE:  cond_o = ~br_lt_i;
      F3_BGEU: cond_o = ~br_lt_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch/jump resolution, PC register, trap FSM and taken counter
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
  parameter int          CNT_W    = 16
) (
  input  logic             pcu_i_clk,
  input  logic             pcu_i_rst_n,
  input  logic             pcu_i_inst_valid,
  input  logic             pcu_i_stall,
  input  logic             pcu_i_is_branch,
  input  logic             pcu_i_is_jal,
  input  logic             pcu_i_is_jalr,
  input  logic [2:0]       pcu_i_funct3,
  input  logic [31:0]      pcu_i_imm,
  input  logic [31:0]      pcu_i_rs1,
  input  logic             pcu_i_br_eq,
  input  logic             pcu_i_br_lt,
  output logic             pcu_o_br_un,
  input  logic             pcu_i_trap_ack,
  output logic [31:0]      pcu_o_pc,
  output logic [31:0]      pcu_o_pc_plus4,
  output logic             pcu_o_taken,
  output logic             pcu_o_flush,
  output logic             pcu_o_misalign,
  output logic [31:0]      pcu_o_bad_addr,
  output logic             pcu_o_illegal,
  output logic [CNT_W-1:0] pcu_o_taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pcu_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      bad_addr_q, bad_addr_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cond;
  logic        f3_illegal;
  logic        running;
  logic        commit;
  logic        taken;
  logic        misalign_hit;
  logic        branch_only;
  logic [31:0] pc_plus4;
  logic [31:0] rel_target;
  logic [31:0] jalr_sum;
  logic [31:0] target;

  branch_cond_dec u_cond_dec (
    .funct3_i  (pcu_i_funct3),
    .br_eq_i   (pcu_i_br_eq),
    .br_lt_i   (pcu_i_br_lt),
    .cond_o    (cond),
    .illegal_o (f3_illegal),
    .br_un_o   (pcu_o_br_un)
  );

  // Target arithmetic wraps silently mod 2^32; JALR clears bit 0 only.
  assign pc_plus4    = pc_q + 32'd4;
  assign rel_target  = pc_q + pcu_i_imm;
  assign jalr_sum    = pcu_i_rs1 + pcu_i_imm;
  assign target      = pcu_i_is_jalr ? {jalr_sum[31:1], 1'b0} : rel_target;

  assign running      = (state_q == ST_RUN);
  assign commit       = running & pcu_i_inst_valid & ~pcu_i_stall;
  assign branch_only  = pcu_i_is_branch & ~pcu_i_is_jal & ~pcu_i_is_jalr;
  assign taken        = running & pcu_i_inst_valid &
                        (pcu_i_is_jal | pcu_i_is_jalr | (branch_only & cond));
  assign misalign_hit = taken & target[1];

  // State register.
  always_ff @(posedge pcu_i_clk or negedge pcu_i_rst_n) begin
    if (!pcu_i_rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: boot for one cycle, trap on misaligned taken commit, vector after ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (commit && misalign_hit) state_d = ST_TRAP;
      ST_TRAP:   if (pcu_i_trap_ack) state_d = ST_VECTOR;
      ST_VECTOR: state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Datapath next values driven by the current state and the committing instruction.
  always_comb begin
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;
    bad_addr_d = bad_addr_q;
    illegal_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (commit) begin
          illegal_d = branch_only & f3_illegal;
          if (misalign_hit) begin
            bad_addr_d = target;
            misalign_d = 1'b1;
          end else if (taken) begin
            pc_d    = target;
            flush_d = 1'b1;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_TRAP: begin
        if (pcu_i_trap_ack) misalign_d = 1'b0;
      end
      ST_VECTOR: begin
        pc_d    = TRAP_VEC;
        flush_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge pcu_i_clk or negedge pcu_i_rst_n) begin
    if (!pcu_i_rst_n) begin
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= 32'h0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output drive.
  always_comb begin
    pcu_o_pc        = pc_q;
    pcu_o_pc_plus4  = pc_plus4;
    pcu_o_taken     = taken;
    pcu_o_flush     = flush_q;
    pcu_o_misalign  = misalign_q;
    pcu_o_bad_addr  = bad_addr_q;
    pcu_o_illegal   = illegal_q;
    pcu_o_taken_cnt = cnt_q;
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TVC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0, stall = 1'b0, br = 1'b0, jal = 1'b0, jalr = 1'b0;
  logic [2:0]    f3 = 3'b000;
  logic [31:0]   imm = 32'h0, rs1 = 32'h0;
  logic          eq = 1'b0, lt = 1'b0, ack = 1'b0;
  logic          br_un, taken, flush, mis, ill;
  logic [31:0]   pc, pc4, bad;
  logic [CW-1:0] cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  branch_pc_unit #(.RESET_PC(RPC), .TRAP_VEC(TVC), .CNT_W(CW)) dut (
    .pcu_i_clk(clk), .pcu_i_rst_n(rst_n), .pcu_i_inst_valid(valid), .pcu_i_stall(stall),
    .pcu_i_is_branch(br), .pcu_i_is_jal(jal), .pcu_i_is_jalr(jalr), .pcu_i_funct3(f3),
    .pcu_i_imm(imm), .pcu_i_rs1(rs1), .pcu_i_br_eq(eq), .pcu_i_br_lt(lt),
    .pcu_o_br_un(br_un), .pcu_i_trap_ack(ack), .pcu_o_pc(pc), .pcu_o_pc_plus4(pc4),
    .pcu_o_taken(taken), .pcu_o_flush(flush), .pcu_o_misalign(mis), .pcu_o_bad_addr(bad),
    .pcu_o_illegal(ill), .pcu_o_taken_cnt(cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural PC, counter, and "where are we" flags.
  logic [31:0] m_pc, m_bad;
  int          m_cnt;
  bit          m_flush, m_mis, m_ill, m_boot, m_trap, m_vec;

  function automatic bit m_cond();
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_running();
    return !m_boot && !m_trap && !m_vec;
  endfunction

  function automatic bit m_taken();
    if (!m_running() || !valid) return 1'b0;
    if (jal || jalr) return 1'b1;
    return br && m_cond();
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (jalr) begin
      s = rs1 + imm;
      s[0] = 1'b0;
      return s;
    end
    return m_pc + imm;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RPC; m_bad = 32'h0; m_cnt = 0;
      m_flush = 0; m_mis = 0; m_ill = 0; m_boot = 1; m_trap = 0; m_vec = 0;
    end else begin
      logic [31:0] t;
      bit nf, ni, tk;
      nf = 0; ni = 0;
      if (m_boot) begin
        m_boot = 0;
      end else if (m_trap) begin
        if (ack) begin m_trap = 0; m_mis = 0; m_vec = 1; end
      end else if (m_vec) begin
        m_pc = TVC; nf = 1; m_vec = 0;
      end else if (valid && !stall) begin
        tk = m_taken();
        t  = m_target();
        ni = br && !jal && !jalr && (f3 == 3'd2 || f3 == 3'd3);
        if (tk && t[1]) begin
          m_mis = 1; m_bad = t; m_trap = 1;
        end else if (tk) begin
          m_pc = t; nf = 1; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      m_flush = nf; m_ill = ni;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc4, m_pc + 32'd4);
      chk("m_taken", {31'b0, taken}, {31'b0, m_taken()});
      chk("m_br_un", {31'b0, br_un}, {31'b0, f3[1]});
      chk("m_flush", {31'b0, flush}, {31'b0, m_flush});
      chk("m_misalign", {31'b0, mis}, {31'b0, m_mis});
      chk("m_bad_addr", bad, m_bad);
      chk("m_illegal", {31'b0, ill}, {31'b0, m_ill});
      chk("m_cnt", {28'b0, cnt}, m_cnt[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic b, input logic j, input logic jr,
                       input logic [2:0] fn, input logic [31:0] im, input logic [31:0] r1,
                       input logic e, input logic l, input logic a);
    valid = v; stall = s; br = b; jal = j; jalr = jr; f3 = fn;
    imm = im; rs1 = r1; eq = e; lt = l; ack = a;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic seq();
    drive(1, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    idle();
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_cnt", {28'b0, cnt}, 32'h0);
    rst_n = 1'b1;

    // Boot cycle: no commit even though an instruction is offered.
    seq();
    tick();
    chk("boot_no_commit", pc, 32'h0);
    repeat (4) tick();
    chk("seq4_pc", pc, 32'h10);
    repeat (12) tick();
    chk("seq_to_40", pc, 32'h40);

    // BEQ taken backwards, then flush drops.
    drive(1, 0, 1, 0, 0, 3'd0, 32'hFFFF_FFF8, 32'h0, 1, 0, 0);
    tick();
    chk("beq_pc", pc, 32'h38);
    chk("beq_flush", {31'b0, flush}, 32'h1);
    idle();
    tick();
    chk("beq_flush_drop", {31'b0, flush}, 32'h0);
    chk("beq_cnt", {28'b0, cnt}, 32'h1);

    // BNE with eq=1 falls through.
    drive(1, 0, 1, 0, 0, 3'd1, 32'h100, 32'h0, 1, 0, 0);
    tick();
    chk("bne_pc", pc, 32'h3C);
    chk("bne_cnt", {28'b0, cnt}, 32'h1);

    // BLTU taken, BLT not taken, reserved funct3 flagged illegal.
    drive(1, 0, 1, 0, 0, 3'd6, 32'h10, 32'h0, 0, 1, 0);
    #1;
    chk("bltu_br_un", {31'b0, br_un}, 32'h1);
    chk("bltu_taken", {31'b0, taken}, 32'h1);
    tick();
    chk("bltu_pc", pc, 32'h4C);
    drive(1, 0, 1, 0, 0, 3'd4, 32'h8, 32'h0, 0, 0, 0);
    #1;
    chk("blt_br_un", {31'b0, br_un}, 32'h0);
    tick();
    chk("blt_pc", pc, 32'h50);
    drive(1, 0, 1, 0, 0, 3'd3, 32'h8, 32'h0, 1, 1, 0);
    tick();
    chk("ill_pulse", {31'b0, ill}, 32'h1);
    chk("ill_pc", pc, 32'h54);
    idle();
    tick();
    chk("ill_drop", {31'b0, ill}, 32'h0);

    // JALR to a misaligned target traps and holds.
    drive(1, 0, 0, 0, 1, 3'd0, 32'h0, 32'h1003, 0, 0, 0);
    tick();
    chk("trap_mis", {31'b0, mis}, 32'h1);
    chk("trap_bad", bad, 32'h1002);
    chk("trap_pc", pc, 32'h54);
    drive(1, 0, 0, 1, 0, 3'd0, 32'h8, 32'h0, 0, 0, 0);
    repeat (3) tick();
    chk("trap_hold_pc", pc, 32'h54);
    chk("trap_hold_mis", {31'b0, mis}, 32'h1);
    ack = 1'b1;
    tick();
    chk("ack_mis_clr", {31'b0, mis}, 32'h0);
    tick();
    chk("vec_pc", pc, 32'h100);
    chk("vec_flush", {31'b0, flush}, 32'h1);
    idle();
    tick();
    chk("vec_flush_drop", {31'b0, flush}, 32'h0);
    chk("vec_cnt", {28'b0, cnt}, 32'h2);

    // Wrap-around of pc_plus4 and of a JAL target.
    drive(1, 0, 0, 0, 1, 3'd0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0);
    tick();
    chk("pc_top", pc, 32'hFFFF_FFFC);
    chk("pc4_wrap", pc4, 32'h0);
    drive(1, 0, 0, 0, 1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, 0);
    tick();
    chk("jalr_f0", pc, 32'hFFFF_FFF0);
    drive(1, 0, 1, 1, 0, 3'd1, 32'h20, 32'h0, 1, 0, 0);
    tick();
    chk("jal_wrap", pc, 32'h10);
    chk("jal_cnt", {28'b0, cnt}, 32'h5);

    // Stalled taken branch: frozen, then a single redirect.
    drive(1, 1, 1, 0, 0, 3'd0, 32'h40, 32'h0, 1, 0, 0);
    repeat (5) tick();
    chk("stall_pc", pc, 32'h10);
    chk("stall_cnt", {28'b0, cnt}, 32'h5);
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 32'h50);
    idle();
    tick();
    chk("unstall_once", pc, 32'h50);
    chk("unstall_cnt", {28'b0, cnt}, 32'h6);

    // Taken counter wraps at 2^CW.
    drive(1, 0, 0, 1, 0, 3'd0, 32'h4, 32'h0, 0, 0, 0);
    for (int i = 0; i < 20 && cnt != {CW{1'b1}}; i++) tick();
    chk("cnt_max", {28'b0, cnt}, 32'hF);
    tick();
    chk("cnt_wrap", {28'b0, cnt}, 32'h0);

    // Reset asserted while trapped.
    drive(1, 0, 0, 0, 1, 3'd0, 32'h0, 32'h2, 0, 0, 0);
    tick();
    chk("trap2_mis", {31'b0, mis}, 32'h1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_trap_mis", {31'b0, mis}, 32'h0);
    chk("rst_trap_pc", pc, RPC);
    chk("rst_trap_bad", bad, 32'h0);
    tick();
    rst_n = 1'b1;
    seq();
    repeat (3) tick();
    chk("post_rst_pc", pc, 32'h8);

    idle();
    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
